// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtraction path.
//   sub_state_t   : controller FSM state encoding
//   DEFAULT_WIDTH : default operand width
package sub_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 32;
endpackage

// File: rtl/sub.sv
// 1-bit full-subtractor cell: computes a - b - cin.
// Ports:
//   a, b, cin : minuend bit, subtrahend bit, borrow in
//   s         : difference bit
//   cout      : borrow out
module sub (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (~a & b) | (~(a ^ b) & cin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller. Feeds one full-subtractor cell LSB first
// for WIDTH cycles, carrying the borrow in a register, then presents the
// result with a one-cycle done pulse.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   start    : request a subtraction (sampled only in IDLE)
//   a_in     : minuend, captured on accepted start
//   b_in     : subtrahend, captured on accepted start
//   busy     : high whenever not IDLE
//   done     : one-cycle pulse, results valid
//   diff     : a - b modulo 2^WIDTH (held until next result)
//   borrow   : unsigned borrow out (a < b)
//   overflow : signed overflow of a - b
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    sub_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, r_sh_q;
    logic             brw_q;
    logic             a_msb_q, b_msb_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q, overflow_q;

    logic cell_s, cell_cout;
    logic last_bit;

    sub u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (brw_q),
        .s    (cell_s),
        .cout (cell_cout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            r_sh_q     <= '0;
            brw_q      <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a_in;
                        b_sh_q  <= b_in;
                        cnt_q   <= '0;
                        brw_q   <= 1'b0;
                        a_msb_q <= a_in[WIDTH-1];
                        b_msb_q <= b_in[WIDTH-1];
                    end
                end
                SHIFT: begin
                    r_sh_q <= {cell_s, r_sh_q[WIDTH-1:1]};
                    a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
                    brw_q  <= cell_cout;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    // Publish the result on the edge that enters DONE so the
                    // outputs are already valid while done is high. The final
                    // difference bit is the cell output of this cycle.
                    if (last_bit) begin
                        diff_q     <= {cell_s, r_sh_q[WIDTH-1:1]};
                        borrow_q   <= cell_cout;
                        overflow_q <= (a_msb_q != b_msb_q) && (cell_s != a_msb_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy, done, borrow, overflow;
    logic [W-1:0] diff;

    int total = 0;
    int bad   = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         brw;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // One complete operation: start pulsed for one edge, then watch done/busy
    // for a bounded number of cycles.
    task automatic do_op(input vec_t v, input int idx);
        int done_at;
        int busy_cnt;
        int done_cnt;
        done_at  = -1;
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        a_in  = v.a;
        b_in  = v.b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (busy) busy_cnt++;
        for (int n = 1; n <= W + 4; n++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
        end
        check($sformatf("v%0d latency", idx), done_at, W);
        check($sformatf("v%0d busy_cycles", idx), busy_cnt, W + 1);
        check($sformatf("v%0d done_count", idx), done_cnt, 1);
        check($sformatf("v%0d diff", idx), diff, v.d);
        check($sformatf("v%0d borrow", idx), borrow, v.brw);
        check($sformatf("v%0d overflow", idx), overflow, v.ovf);
        $display("op %0d: a=0x%02h b=0x%02h -> diff=0x%02h borrow=%0b overflow=%0b",
                 idx, v.a, v.b, diff, borrow, overflow);
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int second_done;

        vecs[0] = '{a: 8'h05, b: 8'h03, d: 8'h02, brw: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, d: 8'hFE, brw: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h80, b: 8'h01, d: 8'h7F, brw: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, brw: 1'b1, ovf: 1'b1};
        vecs[4] = '{a: 8'h00, b: 8'h00, d: 8'h00, brw: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, brw: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 8'hAA, b: 8'h55, d: 8'h55, brw: 1'b0, ovf: 1'b1};
        vecs[7] = '{a: 8'h10, b: 8'h01, d: 8'h0F, brw: 1'b0, ovf: 1'b0};

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst diff", diff, 0);
        check("rst borrow", borrow, 0);
        check("rst overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) do_op(vecs[i], i);

        // start pulses while busy are ignored
        @(negedge clk);
        a_in = 8'h10; b_in = 8'h01; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = (n == 3 || n == 8);
            a_in  = 8'hAA;
            b_in  = 8'h55;
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        start = 1'b0;
        check("busy_ignore done_count", done_cnt, 1);
        check("busy_ignore diff", diff, 8'h0F);
        $display("busy-ignore: dones=%0d diff=0x%02h", done_cnt, diff);

        // start held high: results every W+2 cycles
        @(negedge clk);
        a_in = 8'h05; b_in = 8'h03; start = 1'b1;
        done_cnt = 0; first_done = -1; second_done = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = n;
                else if (second_done < 0) second_done = n;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("held done_count", done_cnt, 3);
        check("held first_done", first_done, W + 1);
        check("held period", second_done - first_done, W + 2);
        check("held diff", diff, 8'h02);
        $display("held-start: dones=%0d first=%0d period=%0d", done_cnt, first_done, second_done - first_done);
        repeat (W + 4) @(posedge clk);

        // Reset in the middle of an operation aborts it
        @(negedge clk);
        a_in = 8'h03; b_in = 8'h05; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort diff", diff, 0);
        check("abort borrow", borrow, 0);
        @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("abort no_done", done_cnt, 0);
        $display("abort: busy=%0b diff=0x%02h dones_after=%0d", busy, diff, done_cnt);

        do_op(vecs[1], 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial subtraction controller. It computes WIDTH-bit A−B by driving one 1-bit full-subtractor cell, LSB first, for WIDTH consecutive cycles. The borrow is carried between bits in a register. It is the area-minimal SUB path option for the MIPS ALU: a multi-cycle unit started by the ALU control and reporting through a done pulse.

Parameters:
WIDTH, 32, operand/result width in bits; legal range WIDTH ≥ 2.
CNT_W, $clog2(WIDTH+1), derived localparam; bit counter width; not overridable.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low
start  input  1  request a subtraction; sampled only in IDLE
a_in  input  WIDTH  minuend, captured on accepted start
b_in  input  WIDTH  subtrahend, captured on accepted start
busy  output  1  high whenever state ≠ IDLE
done  output  1  one-cycle pulse; diff/borrow/overflow valid
diff  output  WIDTH  A−B modulo 2^WIDTH
borrow  output  1  unsigned borrow out, i.e. A < B unsigned
overflow  output  1  two's-complement signed overflow of A−B

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE; busy=0, done=0, diff=0, borrow=0, overflow=0.
  - Counter, shift registers and borrow register cleared.
  - Reset has priority over every other input, including mid-operation; an aborted operation never produces done.
- Cell function, bit i with borrow-in c:
  - s = a^b^c
  - cout = (~a&b) | (~(a^b)&c)
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Load a_sh←a_in, b_sh←b_in, cnt←0, brw←0.
  - Latch a_msb=a_in[WIDTH-1], b_msb=b_in[WIDTH-1].
  - Go to SHIFT.
- IDLE, start=0: stay in IDLE; outputs hold.
- SHIFT, each cycle:
  - Cell inputs are a_sh[0], b_sh[0], brw.
  - r_sh ← {s, r_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; brw←cout; cnt←cnt+1.
  - When cnt==WIDTH-1, transition to DONE on this edge.
- DONE, for exactly one cycle:
  - done=1.
  - diff=r_sh; borrow=brw.
  - overflow=(a_msb≠b_msb)&&(diff[WIDTH-1]≠a_msb).
  - Then go to IDLE.
- Latency: if start is sampled at edge k, done is high between edges k+WIDTH and k+WIDTH+1. busy is high for WIDTH+1 cycles.
- start while busy=1 (SHIFT or DONE) is ignored, not queued. a_in/b_in changes while busy have no effect.
- start held high continuously: a new operation is accepted on the first IDLE cycle after DONE, so throughput is one result per WIDTH+2 cycles.
- diff, borrow and overflow are registered and hold their last result until the next DONE or reset. They do not change during SHIFT.
- No combinational path from any input to any output.

Decomposition:
- Package sub_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t
  - localparam DEFAULT_WIDTH = 32
- One sub-module: the existing 1-bit full-subtractor cell sub (ports a, b, cin, s, cout), instantiated once as the datapath.
- The controller owns the FSM, counter, shift registers and borrow register.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, one-cycle start → done 8 cycles after the start edge; diff=0x02, borrow=0, overflow=0; busy high 9 cycles.
- a=0x03, b=0x05 → diff=0xFE, borrow=1, overflow=0.
- a=0x80, b=0x01 → diff=0x7F, borrow=0, overflow=1. Then a=0x7F, b=0xFF → diff=0x80, borrow=1, overflow=1.
- a=0x00, b=0x00 → diff=0x00, borrow=0, overflow=0. Then a=0xFF, b=0xFF → diff=0x00, borrow=0.
- Start a=0x10, b=0x01; pulse start with a=0xAA, b=0x55 at cycles 3 and 8 (busy) → only one done, diff=0x0F. With start held high → back-to-back results every 10 cycles.
- Start an operation, drive rst=0 at cycle 4 for one edge → busy=0, done=0, diff=0 next cycle; no done ever pulses for the aborted op. A fresh start then completes normally.
